// File: rtl/subleq_sync_ram_if.sv
// rtl/subleq_sync_ram_if.sv - request/response bus between subleq control and its main memory
interface subleq_sync_ram_if #(
   parameter int DW = 8,
   parameter int AW = 8
);
   logic          req;
   logic          we;
   logic [AW-1:0] adr;
   logic [DW-1:0] wdat;
   logic          clr;
   logic          rdy;
   logic          busy;
   logic          rvld;
   logic [DW-1:0] rdat;

   modport master (
      output req, we, adr, wdat, clr,
      input  rdy, busy, rvld, rdat
   );

   modport slave (
      input  req, we, adr, wdat, clr,
      output rdy, busy, rvld, rdat
   );
endinterface

// File: rtl/subleq_sync_ram.sv
// rtl/subleq_sync_ram.sv - clocked subleq main memory with req/rdy handshake, read pipeline and clear sequencer
module subleq_sync_ram #(
   parameter int DW      = 8,
   parameter int AW      = 8,
   parameter int RD_LAT  = 1,
   parameter int CLR_RST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   subleq_sync_ram_if.slave bus
);
   localparam int DEPTH = 2 ** AW;

   typedef enum logic {IDLE, CLR} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] clr_ptr, clr_ptr_nxt;
   logic          rdy_q, busy_q;
   logic          rvld_q;
   logic [DW-1:0] rdat_q;
   logic          acc, acc_wr, acc_rd, clr_wr;
   logic [DW-1:0] rd_word;
   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= (CLR_RST != 0) ? CLR : IDLE;
         clr_ptr <= '0;
         rdy_q   <= 1'b0;
         busy_q  <= (CLR_RST != 0);
      end else begin
         state   <= state_nxt;
         clr_ptr <= clr_ptr_nxt;
         rdy_q   <= (state_nxt == IDLE);
         busy_q  <= (state_nxt == CLR);
      end
   end

   // clr wins over a same-cycle req, so the request is simply not accepted
   always_comb begin
      state_nxt   = state;
      clr_ptr_nxt = clr_ptr;
      clr_wr      = 1'b0;
      acc         = 1'b0;
      case (state)
         IDLE: begin
            if (bus.clr) begin
               state_nxt   = CLR;
               clr_ptr_nxt = '0;
            end else begin
               acc = bus.req & rdy_q;
            end
         end
         CLR: begin
            clr_wr      = 1'b1;
            clr_ptr_nxt = clr_ptr + 1'b1;
            if (&clr_ptr) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign acc_wr  = acc & bus.we;
   assign acc_rd  = acc & ~bus.we;
   assign rd_word = mem[bus.adr];

   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (clr_wr)      mem[clr_ptr] <= '0;
         else if (acc_wr) mem[bus.adr] <= bus.wdat;
      end
   end

   generate
      if (RD_LAT == 1) begin : g_lat1
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rvld_q <= 1'b0;
               rdat_q <= '0;
            end else begin
               rvld_q <= acc_rd;
               if (acc_rd) rdat_q <= rd_word;
            end
         end
      end else if (RD_LAT == 2) begin : g_lat2
         logic          v1;
         logic [DW-1:0] d1;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v1     <= 1'b0;
               d1     <= '0;
               rvld_q <= 1'b0;
               rdat_q <= '0;
            end else begin
               v1     <= acc_rd;
               if (acc_rd) d1 <= rd_word;
               rvld_q <= v1;
               if (v1) rdat_q <= d1;
            end
         end
      end else begin : g_bad_lat
         $error("subleq_sync_ram: RD_LAT must be 1 or 2");
      end
   endgenerate

   assign bus.rdy  = rdy_q;
   assign bus.busy = busy_q;
   assign bus.rvld = rvld_q;
   assign bus.rdat = rdat_q;
endmodule

// File: tb/tb_subleq_sync_ram.sv
// tb/tb_subleq_sync_ram.sv - scoreboard bench for subleq_sync_ram, RD_LAT 1 and 2 side by side
module tb_subleq_sync_ram;
   localparam int DW    = 8;
   localparam int AW    = 8;
   localparam int DEPTH = 256;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          req   = 1'b0;
   logic          we    = 1'b0;
   logic          clr   = 1'b0;
   logic [AW-1:0] adr   = '0;
   logic [DW-1:0] wdat  = '0;

   always #5 clk = ~clk;

   subleq_sync_ram_if #(.DW(DW), .AW(AW)) bus1 ();
   subleq_sync_ram_if #(.DW(DW), .AW(AW)) bus2 ();

   assign bus1.req = req;  assign bus1.we = we;  assign bus1.adr = adr;
   assign bus1.wdat = wdat; assign bus1.clr = clr;
   assign bus2.req = req;  assign bus2.we = we;  assign bus2.adr = adr;
   assign bus2.wdat = wdat; assign bus2.clr = clr;

   subleq_sync_ram #(.DW(DW), .AW(AW), .RD_LAT(1), .CLR_RST(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
   subleq_sync_ram #(.DW(DW), .AW(AW), .RD_LAT(2), .CLR_RST(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

   typedef struct {
      logic [DW-1:0] d;
      int            due;
   } exp_t;

   int            errors = 0;
   int            checks = 0;
   int            cyc    = 0;
   logic [DW-1:0] ref_mem [DEPTH];
   bit            m_clearing = 1'b1;
   int            m_left = DEPTH;
   int            m_ptr  = 0;
   exp_t          q1[$];
   exp_t          q2[$];
   logic [DW-1:0] last1 = '0;
   logic [DW-1:0] last2 = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int qsize(input int ln);
      return (ln == 1) ? q1.size() : q2.size();
   endfunction

   function automatic int qdue(input int ln);
      return (ln == 1) ? q1[0].due : q2[0].due;
   endfunction

   function automatic exp_t qpop(input int ln);
      if (ln == 1) return q1.pop_front();
      return q2.pop_front();
   endfunction

   // Reference model: memory as an array, clear as a countdown, reads as timed expectations
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_clearing = 1'b1;
            m_left     = DEPTH;
            m_ptr      = 0;
            q1.delete();
            q2.delete();
            last1 = '0;
            last2 = '0;
         end else if (m_clearing) begin
            ref_mem[m_ptr] = '0;
            m_ptr  = (m_ptr + 1) % DEPTH;
            m_left = m_left - 1;
            if (m_left == 0) m_clearing = 1'b0;
         end else if (clr) begin
            m_clearing = 1'b1;
            m_left     = DEPTH;
            m_ptr      = 0;
         end else if (req) begin
            if (we) begin
               ref_mem[adr] = wdat;
            end else begin
               e.d = ref_mem[adr];
               e.due = cyc + 1; q1.push_back(e);
               e.due = cyc + 2; q2.push_back(e);
            end
         end
      end
   end

   task automatic check_lane(input int ln, input logic rv, input logic [DW-1:0] rd);
      exp_t e;
      while (qsize(ln) > 0 && qdue(ln) < cyc) begin
         e = qpop(ln);
         checks++;
         errors++;
         $display("FAIL rvld_missing lane%0d: got no rvld, expected data %0h at cyc %0d", ln, e.d, e.due);
      end
      if (rv) begin
         if (qsize(ln) == 0) begin
            checks++;
            errors++;
            $display("FAIL rvld_spurious lane%0d: got rvld with data %0h, expected none (cyc %0d)", ln, rd, cyc);
         end else begin
            e = qpop(ln);
            chk($sformatf("rdat_lane%0d", ln), rd, e.d);
            chk($sformatf("rvld_cycle_lane%0d", ln), cyc, e.due);
            if (ln == 1) last1 = e.d; else last2 = e.d;
         end
      end else begin
         chk($sformatf("rdat_hold_lane%0d", ln), rd, (ln == 1) ? last1 : last2);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         cyc = cyc + 1;
         chk("rdy1", bus1.rdy, !m_clearing);
         chk("busy1", bus1.busy, m_clearing);
         chk("rdy2", bus2.rdy, !m_clearing);
         chk("busy2", bus2.busy, m_clearing);
         if (!rst_n) begin
            chk("rst_rvld1", bus1.rvld, 1'b0);
            chk("rst_rvld2", bus2.rvld, 1'b0);
            chk("rst_rdat1", bus1.rdat, '0);
            chk("rst_rdat2", bus2.rdat, '0);
         end else begin
            check_lane(1, bus1.rvld, bus1.rdat);
            check_lane(2, bus2.rvld, bus2.rdat);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      req = 1'b1; we = 1'b1; adr = a; wdat = d;
      step();
      req = 1'b0; we = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a);
      req = 1'b1; we = 1'b0; adr = a;
      step();
      req = 1'b0;
   endtask

   task automatic clear_len(input string name);
      int n = 0;
      while (bus1.busy && n < 1000) begin
         n++;
         step();
      end
      chk(name, n, DEPTH);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time bound");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) step();
      rst_n = 1'b1;
      clear_len("clear_len_after_reset");

      rd(8'h00); rd(8'h7F); rd(8'hFF);
      repeat (3) step();

      wr(8'h10, 8'hA5);
      rd(8'h10);
      repeat (3) step();
      chk("rdat_hold_a5", bus1.rdat, 8'hA5);

      wr(8'h01, 8'h11); wr(8'h02, 8'h22); wr(8'h03, 8'h33);
      rd(8'h01); rd(8'h02); rd(8'h03);
      repeat (4) step();
      chk("lat2_last_data", bus2.rdat, 8'h33);

      wr(8'h05, 8'h77);
      clr = 1'b1; req = 1'b1; we = 1'b1; adr = 8'h05; wdat = 8'h5A;
      step();
      clr = 1'b0; req = 1'b0; we = 1'b0;
      clear_len("clear_len_on_clr");
      rd(8'h05);
      repeat (3) step();
      chk("clr_beats_write", bus1.rdat, 8'h00);

      wr(8'h10, 8'hC3);
      rd(8'h10);
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      clear_len("clear_len_after_inflight_reset");

      clr = 1'b1;
      step();
      clr = 1'b0;
      repeat (8'h40) step();
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      req = 1'b1; we = 1'b0; adr = 8'h40;
      clear_len("clear_len_after_midclear_reset");
      repeat (3) step();
      req = 1'b0;
      repeat (3) step();

      for (int i = 0; i < 400; i++) begin
         req  = ($urandom_range(0, 9) < 7);
         we   = $urandom_range(0, 1) == 1;
         adr  = AW'($urandom_range(0, 7));
         wdat = DW'($urandom);
         clr  = ($urandom_range(0, 199) == 0);
         step();
      end
      req = 1'b0; we = 1'b0; clr = 1'b0;
      begin
         int n = 0;
         while (!bus1.rdy && n < 600) begin
            n++;
            step();
         end
         chk("final_rdy", bus1.rdy, 1'b1);
      end
      for (int a = 0; a < 8; a++) rd(AW'(a));
      repeat (4) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
